vga_fb_fill_arbiter: RTL and testbench
======================================

Name: vga_fb_fill_arbiter

Overview:
Owns the framebuffer write port (15-bit address, 12-bit RGB444 data, write enable) of the 160x120 VGA framebuffer. It shares that port between MCU stores and a hardware rectangle-fill engine. MCU writes always win; the fill engine stalls for that cycle and resumes without losing a pixel. It sits between the OTTER MMIO write path and the framebuffer's WA/WD/WE inputs.

Parameters:
H_PIXELS, 160, framebuffer width; legal X is 0..H_PIXELS-1
V_PIXELS, 120, framebuffer height; legal Y is 0..V_PIXELS-1

Ports:
CLK_50MHz  in  1  system clock; same clock as the framebuffer write port
RST  in  1  asynchronous, active-high reset
CPU_WA  in  15  MCU write address, {y[6:0], x[7:0]}
CPU_WD  in  12  MCU write data, RGB444
CPU_WE  in  1  MCU write strobe; one write per cycle high
FILL_X0  in  8  rectangle left column, inclusive
FILL_Y0  in  7  rectangle top row, inclusive
FILL_X1  in  8  rectangle right column, inclusive
FILL_Y1  in  7  rectangle bottom row, inclusive
FILL_COLOR  in  12  fill colour, RGB444
FILL_START  in  1  single-cycle start request
FILL_ABORT  in  1  stops an in-progress fill
FILL_BUSY  out  1  high while state is not IDLE
FILL_DONE  out  1  one-cycle pulse when a fill completes normally
FILL_ERR  out  1  one-cycle pulse when a START is rejected
FB_WA  out  15  framebuffer write address
FB_WD  out  12  framebuffer write data
FB_WE  out  1  framebuffer write enable

Behaviour:
- Reset (async, RST=1):
  - state = IDLE
  - FB_WA, FB_WD, FB_WE, FILL_BUSY, FILL_DONE and FILL_ERR all 0
  - internal X/Y counters and latched parameters cleared
- Outputs: FB_WA, FB_WD, FB_WE, FILL_DONE and FILL_ERR are registered. FILL_BUSY = (state != IDLE).
- Address format: FB_WA = {y[6:0], x[7:0]}.
- Write-port selection, evaluated every edge, first match wins:
  1. CPU_WE=1: FB_WE<=1, FB_WA<=CPU_WA, FB_WD<=CPU_WD. This is one-cycle latency and does not depend on state.
  2. state=FILL: FB_WE<=1, FB_WA<={cy,cx}, FB_WD<=latched colour, then advance the counters.
  3. Otherwise: FB_WE<=0. FB_WA and FB_WD hold their previous values.
- When an MCU write takes the port during FILL, the counters do not advance. The stalled pixel is written on the next free cycle.
- States: IDLE, FILL, DONE.
- IDLE, with FILL_START=1:
  - If X0<=X1<H_PIXELS and Y0<=Y1<V_PIXELS: latch X0, Y0, X1, Y1 and COLOR; set cx=X0, cy=Y0; go to FILL.
  - Otherwise: pulse FILL_ERR for one cycle and stay in IDLE.
- FILL, on each granted pixel (advance rule):
  - If cx==X1 and cy==Y1: this is the last pixel; go to DONE.
  - Else if cx==X1: cx=X0, cy=cy+1.
  - Else: cx=cx+1.
- DONE: FILL_DONE<=1 for exactly one cycle, then go to IDLE. FILL_BUSY is still high during the DONE cycle.
- Throughput: an uncontended fill of N pixels that starts at edge k produces fill writes on FB_* in cycles k+1..k+N. FILL_DONE is high in cycle k+N+1, and FILL_BUSY falls after that.
- FILL_START while not IDLE: ignored, with no FILL_ERR pulse. Input parameter changes during a fill have no effect.
- FILL_ABORT while in FILL: go to IDLE at the next edge, with no FILL_DONE. Any pixel granted at that same edge is still emitted. FILL_ABORT outside FILL is ignored, and ABORT takes priority over completion in the same cycle.
- A 1x1 rectangle is legal: exactly one write, then DONE.
- Reset mid-fill: outputs clear immediately and the partial fill is abandoned.

Test Plan:
- MCU passthrough, idle: CPU_WE=1, CPU_WA=0x1234, CPU_WD=0xF0A -> the next cycle shows FB_WE=1, FB_WA=0x1234, FB_WD=0xF0A. FILL_BUSY stays 0.
- Uncontended fill: X0=2, X1=4, Y0=5, Y1=6, COLOR=0x0F0 -> six consecutive writes to 0x0502, 0x0503, 0x0504, 0x0602, 0x0603, 0x0604, all with data 0x0F0. FILL_DONE pulses once in the following cycle.
- Contention: same fill with CPU_WE held for 2 cycles during the 3rd pixel -> the MCU writes appear in those slots, then 0x0504 follows. Total fill writes = 6, and DONE is delayed by 2 cycles.
- Rejected start: X0=10, X1=9 or Y1=120 -> FILL_ERR pulses for 1 cycle, no FB writes, BUSY stays 0.
- Abort and restart: abort a full-screen fill (0,0,159,119) after 100 writes -> no FILL_DONE, BUSY=0 on the next cycle. A new 1x1 fill at (159,119) then writes FB_WA=0x779F once and DONE pulses.
- Async reset mid-fill -> FB_WE, FILL_BUSY, FB_WA and FB_WD are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vga_fb_fill_arbiter_if.sv
// Bus bundle for vga_fb_fill_arbiter: MCU write path, fill-engine control and
// the framebuffer write port.
//   slave  : view taken by the arbiter (CPU_*/FILL_* in, FB_*/status out)
//   master : view taken by whatever drives the MCU and fill requests
interface vga_fb_fill_arbiter_if;
    logic [14:0] CPU_WA;
    logic [11:0] CPU_WD;
    logic        CPU_WE;
    logic [7:0]  FILL_X0;
    logic [6:0]  FILL_Y0;
    logic [7:0]  FILL_X1;
    logic [6:0]  FILL_Y1;
    logic [11:0] FILL_COLOR;
    logic        FILL_START;
    logic        FILL_ABORT;
    logic        FILL_BUSY;
    logic        FILL_DONE;
    logic        FILL_ERR;
    logic [14:0] FB_WA;
    logic [11:0] FB_WD;
    logic        FB_WE;

    modport slave (
        input  CPU_WA, CPU_WD, CPU_WE,
        input  FILL_X0, FILL_Y0, FILL_X1, FILL_Y1, FILL_COLOR,
        input  FILL_START, FILL_ABORT,
        output FILL_BUSY, FILL_DONE, FILL_ERR,
        output FB_WA, FB_WD, FB_WE
    );

    modport master (
        output CPU_WA, CPU_WD, CPU_WE,
        output FILL_X0, FILL_Y0, FILL_X1, FILL_Y1, FILL_COLOR,
        output FILL_START, FILL_ABORT,
        input  FILL_BUSY, FILL_DONE, FILL_ERR,
        input  FB_WA, FB_WD, FB_WE
    );
endinterface

// File: rtl/vga_fb_fill_arbiter.sv
// Framebuffer write-port arbiter: MCU stores always win the port; a rectangle
// fill engine writes {y,x} pixels on every cycle the MCU leaves free.
//   CLK_50MHz : system clock (same as framebuffer write port)
//   RST       : asynchronous active-high reset
//   bus       : slave modport - CPU_* store, FILL_* request/status, FB_* write port
module vga_fb_fill_arbiter #(
    parameter int unsigned H_PIXELS = 160,
    parameter int unsigned V_PIXELS = 120
) (
    input  logic                  CLK_50MHz,
    input  logic                  RST,
    vga_fb_fill_arbiter_if.slave  bus
);
    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned CW = 12;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t          state, state_n;
    logic [XW-1:0]   cx, cx_n, x0, x0_n, x1, x1_n;
    logic [YW-1:0]   cy, cy_n, y0, y0_n, y1, y1_n;
    logic [CW-1:0]   color, color_n;
    logic [XW+YW-1:0] fb_wa, fb_wa_n;
    logic [CW-1:0]   fb_wd, fb_wd_n;
    logic            fb_we, fb_we_n;
    logic            done, done_n;
    logic            err, err_n;
    logic            grant;
    logic            req_ok;

    // Start request is legal only for a non-empty rectangle inside the screen
    assign req_ok = (bus.FILL_X0 <= bus.FILL_X1) && (32'(bus.FILL_X1) < H_PIXELS) &&
                    (bus.FILL_Y0 <= bus.FILL_Y1) && (32'(bus.FILL_Y1) < V_PIXELS);

    // State and output registers
    always_ff @(posedge CLK_50MHz or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            cx    <= '0;
            cy    <= '0;
            x0    <= '0;
            x1    <= '0;
            y0    <= '0;
            y1    <= '0;
            color <= '0;
            fb_wa <= '0;
            fb_wd <= '0;
            fb_we <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cx    <= cx_n;
            cy    <= cy_n;
            x0    <= x0_n;
            x1    <= x1_n;
            y0    <= y0_n;
            y1    <= y1_n;
            color <= color_n;
            fb_wa <= fb_wa_n;
            fb_wd <= fb_wd_n;
            fb_we <= fb_we_n;
            done  <= done_n;
            err   <= err_n;
        end
    end

    // Next-state, port selection and raster counter advance
    always_comb begin
        state_n = state;
        cx_n    = cx;
        cy_n    = cy;
        x0_n    = x0;
        x1_n    = x1;
        y0_n    = y0;
        y1_n    = y1;
        color_n = color;
        fb_wa_n = fb_wa;
        fb_wd_n = fb_wd;
        fb_we_n = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        grant   = 1'b0;

        // MCU first; the fill engine only gets cycles the MCU leaves idle
        if (bus.CPU_WE) begin
            fb_we_n = 1'b1;
            fb_wa_n = bus.CPU_WA;
            fb_wd_n = bus.CPU_WD;
        end else if (state == S_FILL) begin
            fb_we_n = 1'b1;
            fb_wa_n = {cy, cx};
            fb_wd_n = color;
            grant   = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (bus.FILL_START) begin
                    if (req_ok) begin
                        x0_n    = bus.FILL_X0;
                        x1_n    = bus.FILL_X1;
                        y0_n    = bus.FILL_Y0;
                        y1_n    = bus.FILL_Y1;
                        color_n = bus.FILL_COLOR;
                        cx_n    = bus.FILL_X0;
                        cy_n    = bus.FILL_Y0;
                        state_n = S_FILL;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_FILL: begin
                // Abort wins over completion; a pixel granted now is still emitted
                if (bus.FILL_ABORT) begin
                    state_n = S_IDLE;
                end else if (grant) begin
                    if (cx == x1 && cy == y1) begin
                        state_n = S_DONE;
                    end else if (cx == x1) begin
                        cx_n = x0;
                        cy_n = YW'(cy + YW'(1));
                    end else begin
                        cx_n = XW'(cx + XW'(1));
                    end
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.FB_WA     = fb_wa;
    assign bus.FB_WD     = fb_wd;
    assign bus.FB_WE     = fb_we;
    assign bus.FILL_DONE = done;
    assign bus.FILL_ERR  = err;
    assign bus.FILL_BUSY = (state != S_IDLE);
endmodule

// File: tb/tb_vga_fb_fill_arbiter.sv
// Directed bench for vga_fb_fill_arbiter: MCU passthrough, uncontended fill,
// MCU contention, rejected starts, abort/restart, async reset mid-fill.
module tb_vga_fb_fill_arbiter;
    logic CLK_50MHz;
    logic RST;
    int   n_checks;
    int   n_fail;

    vga_fb_fill_arbiter_if ifc ();

    vga_fb_fill_arbiter #(.H_PIXELS(160), .V_PIXELS(120)) dut (
        .CLK_50MHz (CLK_50MHz),
        .RST       (RST),
        .bus       (ifc.slave)
    );

    initial CLK_50MHz = 1'b0;
    always #10 CLK_50MHz = ~CLK_50MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample away from it
    task automatic step();
        @(posedge CLK_50MHz);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [14:0] wa, input logic [11:0] wd);
        check({tag, ".we"}, 32'(ifc.FB_WE), 32'd1);
        check({tag, ".wa"}, 32'(ifc.FB_WA), 32'(wa));
        check({tag, ".wd"}, 32'(ifc.FB_WD), 32'(wd));
    endtask

    task automatic set_rect(input logic [7:0] x0, input logic [6:0] y0,
                            input logic [7:0] x1, input logic [6:0] y1,
                            input logic [11:0] col);
        ifc.FILL_X0    = x0;
        ifc.FILL_Y0    = y0;
        ifc.FILL_X1    = x1;
        ifc.FILL_Y1    = y1;
        ifc.FILL_COLOR = col;
    endtask

    logic [14:0] exp_wa [6];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_wa   = '{15'h0502, 15'h0503, 15'h0504, 15'h0602, 15'h0603, 15'h0604};
        RST            = 1'b1;
        ifc.CPU_WA     = '0;
        ifc.CPU_WD     = '0;
        ifc.CPU_WE     = 1'b0;
        ifc.FILL_START = 1'b0;
        ifc.FILL_ABORT = 1'b0;
        set_rect(8'd0, 7'd0, 8'd0, 7'd0, 12'h000);

        // Reset state
        step();
        step();
        check("rst.we",   32'(ifc.FB_WE), 32'd0);
        check("rst.wa",   32'(ifc.FB_WA), 32'd0);
        check("rst.wd",   32'(ifc.FB_WD), 32'd0);
        check("rst.busy", 32'(ifc.FILL_BUSY), 32'd0);
        check("rst.done", 32'(ifc.FILL_DONE), 32'd0);
        check("rst.err",  32'(ifc.FILL_ERR), 32'd0);
        RST = 1'b0;

        // MCU passthrough while idle
        ifc.CPU_WE = 1'b1;
        ifc.CPU_WA = 15'h1234;
        ifc.CPU_WD = 12'hF0A;
        step();
        chk_wr("cpu", 15'h1234, 12'hF0A);
        check("cpu.busy", 32'(ifc.FILL_BUSY), 32'd0);
        ifc.CPU_WE = 1'b0;
        step();
        check("cpu.idle_we", 32'(ifc.FB_WE), 32'd0);
        check("cpu.hold_wa", 32'(ifc.FB_WA), 32'h1234);

        // Uncontended 3x2 fill
        set_rect(8'd2, 7'd5, 8'd4, 7'd6, 12'h0F0);
        ifc.FILL_START = 1'b1;
        step();
        ifc.FILL_START = 1'b0;
        check("fill.busy0", 32'(ifc.FILL_BUSY), 32'd1);
        check("fill.we0",   32'(ifc.FB_WE), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk_wr($sformatf("fill.px%0d", i), exp_wa[i], 12'h0F0);
            check($sformatf("fill.nodone%0d", i), 32'(ifc.FILL_DONE), 32'd0);
        end
        check("fill.busy_done", 32'(ifc.FILL_BUSY), 32'd1);
        step();
        check("fill.done", 32'(ifc.FILL_DONE), 32'd1);
        check("fill.we_end", 32'(ifc.FB_WE), 32'd0);
        step();
        check("fill.done_pulse", 32'(ifc.FILL_DONE), 32'd0);
        check("fill.busy_end", 32'(ifc.FILL_BUSY), 32'd0);

        // Same fill with the MCU taking two cycles at the third pixel
        ifc.FILL_START = 1'b1;
        step();
        ifc.FILL_START = 1'b0;
        step();
        chk_wr("cont.px0", 15'h0502, 12'h0F0);
        step();
        chk_wr("cont.px1", 15'h0503, 12'h0F0);
        ifc.CPU_WE = 1'b1;
        ifc.CPU_WA = 15'h0100;
        ifc.CPU_WD = 12'hAAA;
        step();
        chk_wr("cont.cpu0", 15'h0100, 12'hAAA);
        ifc.CPU_WA = 15'h0101;
        ifc.CPU_WD = 12'hBBB;
        step();
        chk_wr("cont.cpu1", 15'h0101, 12'hBBB);
        ifc.CPU_WE = 1'b0;
        for (int i = 2; i < 6; i++) begin
            step();
            chk_wr($sformatf("cont.px%0d", i), exp_wa[i], 12'h0F0);
            check($sformatf("cont.nodone%0d", i), 32'(ifc.FILL_DONE), 32'd0);
        end
        step();
        check("cont.done", 32'(ifc.FILL_DONE), 32'd1);
        check("cont.busy", 32'(ifc.FILL_BUSY), 32'd0);

        // Rejected starts: X0>X1, then Y1 off-screen
        set_rect(8'd10, 7'd0, 8'd9, 7'd0, 12'h123);
        ifc.FILL_START = 1'b1;
        step();
        ifc.FILL_START = 1'b0;
        check("rej1.err",  32'(ifc.FILL_ERR), 32'd1);
        check("rej1.busy", 32'(ifc.FILL_BUSY), 32'd0);
        check("rej1.we",   32'(ifc.FB_WE), 32'd0);
        step();
        check("rej1.err_pulse", 32'(ifc.FILL_ERR), 32'd0);
        check("rej1.we2", 32'(ifc.FB_WE), 32'd0);
        set_rect(8'd0, 7'd0, 8'd1, 7'd120, 12'h123);
        ifc.FILL_START = 1'b1;
        step();
        ifc.FILL_START = 1'b0;
        check("rej2.err",  32'(ifc.FILL_ERR), 32'd1);
        check("rej2.busy", 32'(ifc.FILL_BUSY), 32'd0);
        step();
        check("rej2.we", 32'(ifc.FB_WE), 32'd0);

        // Full-screen fill aborted after 100 writes
        set_rect(8'd0, 7'd0, 8'd159, 7'd119, 12'h00F);
        ifc.FILL_START = 1'b1;
        step();
        ifc.FILL_START = 1'b0;
        for (int i = 0; i < 100; i++) step();
        chk_wr("abort.px99", 15'h0063, 12'h00F);
        ifc.FILL_ABORT = 1'b1;
        step();
        ifc.FILL_ABORT = 1'b0;
        chk_wr("abort.px100", 15'h0064, 12'h00F);
        check("abort.busy", 32'(ifc.FILL_BUSY), 32'd0);
        step();
        check("abort.we",   32'(ifc.FB_WE), 32'd0);
        check("abort.done", 32'(ifc.FILL_DONE), 32'd0);

        // 1x1 fill at the bottom-right corner
        set_rect(8'd159, 7'd119, 8'd159, 7'd119, 12'hC3C);
        ifc.FILL_START = 1'b1;
        step();
        ifc.FILL_START = 1'b0;
        step();
        chk_wr("one.px", 15'h779F, 12'hC3C);
        check("one.busy", 32'(ifc.FILL_BUSY), 32'd1);
        step();
        check("one.we",   32'(ifc.FB_WE), 32'd0);
        check("one.done", 32'(ifc.FILL_DONE), 32'd1);
        step();
        check("one.done_pulse", 32'(ifc.FILL_DONE), 32'd0);

        // Async reset mid-fill clears outputs without a clock edge
        set_rect(8'd1, 7'd1, 8'd3, 7'd3, 12'hFFF);
        ifc.FILL_START = 1'b1;
        step();
        ifc.FILL_START = 1'b0;
        step();
        chk_wr("arst.px0", 15'h0101, 12'hFFF);
        #2;
        RST = 1'b1;
        #1;
        check("arst.we",   32'(ifc.FB_WE), 32'd0);
        check("arst.busy", 32'(ifc.FILL_BUSY), 32'd0);
        check("arst.wa",   32'(ifc.FB_WA), 32'd0);
        check("arst.wd",   32'(ifc.FB_WD), 32'd0);
        step();
        RST = 1'b0;
        step();
        check("arst.after_we",   32'(ifc.FB_WE), 32'd0);
        check("arst.after_busy", 32'(ifc.FILL_BUSY), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
